// File: rtl/fp_cvt_f2i_pipe.sv
// fp_cvt_f2i_pipe: pipelined float-to-integer converter (W/WU/L/LU) with RISC-V
// rounding, saturation and a passthrough tag. Stages: S1 decode/shift, S2 round,
// S3 saturate/negate; with fewer STAGES the later splits merge combinationally.
// Optional sticky flag accumulator: define FP_CVT_F2I_FLAG_ACC_EN.
module fp_cvt_f2i_pipe #(
    parameter int unsigned XLEN   = 64,
    parameter int unsigned STAGES = 3,
    parameter int unsigned TAG_W  = 5
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [64:0]      in_data,
    input  logic [9:0]       in_class,
    input  logic [1:0]       in_op,
    input  logic [2:0]       in_rm,
    input  logic [TAG_W-1:0] in_tag,
    input  logic             kill,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_result,
    output logic [4:0]       out_flags,
`ifdef FP_CVT_F2I_FLAG_ACC_EN
    input  logic             flags_clr,
    output logic [4:0]       flags_acc,
`endif
    output logic [TAG_W-1:0] out_tag
);

    // Decoded and aligned operand: integer magnitude plus guard/round/sticky
    typedef struct packed {
        logic        sign;
        logic        big;      // magnitude >= 2^64, out of range for every op
        logic        is_nan;
        logic        is_inf;
        logic        illegal;  // 64-bit op on a 32-bit build
        logic        rm_bad;
        logic [1:0]  op;
        logic [2:0]  rm;
        logic [63:0] mag;
        logic        g;
        logic        r;
        logic        s;
    } dec_t;

    // Rounded magnitude; one extra bit catches the carry out of 2^64-1
    typedef struct packed {
        logic        sign;
        logic        big;
        logic        is_nan;
        logic        is_inf;
        logic        illegal;
        logic        rm_bad;
        logic [1:0]  op;
        logic [64:0] mag;
        logic        nx;
    } rnd_t;

    typedef struct packed {
        logic [XLEN-1:0] result;
        logic [4:0]      flags;
    } res_t;

    // S1: unbias the exponent and align the mantissa to the binary point
    function automatic dec_t f_decode(input logic [64:0] data, input logic [9:0] cls,
                                      input logic [1:0] op, input logic [2:0] rm);
        dec_t               d;
        logic [52:0]        mant;
        logic signed [13:0] e;
        logic signed [13:0] rsh;
        logic [5:0]         rs;
        logic [116:0]       wide;
        d         = '0;
        d.sign    = data[64];
        d.is_nan  = cls[8] | cls[9];
        d.is_inf  = cls[0] | cls[7];
        d.illegal = (XLEN == 32) & op[1];
        d.rm_bad  = (rm > 3'd4);
        d.op      = op;
        d.rm      = rm;
        mant      = {~(cls[3] | cls[4]), data[51:0]};
        e         = $signed({2'b00, data[63:52]}) - 14'sd2047;
        rsh       = 14'sd52 - e;
        // Beyond 55 every mantissa bit already lands in sticky
        rs        = (rsh > 14'sd55) ? 6'd55 : rsh[5:0];
        wide      = {mant, 64'd0} >> rs;
        if (e > 14'sd63) begin
            d.big = |mant;
        end else if (e > 14'sd52) begin
            d.mag = {11'd0, mant} << (e[5:0] - 6'd52);
        end else begin
            d.mag = {11'd0, wide[116:64]};
            d.g   = wide[63];
            d.r   = wide[62];
            d.s   = |wide[61:0];
        end
        return d;
    endfunction

    // S2: apply the rounding mode to the magnitude
    function automatic rnd_t f_round(input dec_t d);
        rnd_t o;
        logic inx;
        logic up;
        o   = '0;
        inx = d.g | d.r | d.s;
        case (d.rm)
            3'd0:    up = d.g & (d.mag[0] | d.r | d.s);
            3'd1:    up = 1'b0;
            3'd2:    up = d.sign & inx;
            3'd3:    up = ~d.sign & inx;
            3'd4:    up = d.g;
            default: up = 1'b0;
        endcase
        o.sign    = d.sign;
        o.big     = d.big;
        o.is_nan  = d.is_nan;
        o.is_inf  = d.is_inf;
        o.illegal = d.illegal;
        o.rm_bad  = d.rm_bad;
        o.op      = d.op;
        o.mag     = {1'b0, d.mag} + {64'd0, up};
        o.nx      = inx;
        return o;
    endfunction

    // S3: range check, saturation, negation and 32-bit sign extension
    function automatic res_t f_saturate(input rnd_t x);
        res_t        o;
        logic [64:0] lim_pos;
        logic [64:0] lim_neg;
        logic [63:0] max_v;
        logic [63:0] min_v;
        logic [63:0] res64;
        logic [4:0]  flags;
        logic        ovf;
        case (x.op)
            2'd0: begin
                lim_pos = 65'h0_7FFF_FFFF;
                lim_neg = 65'h0_8000_0000;
                max_v   = 64'h0000_0000_7FFF_FFFF;
                min_v   = 64'hFFFF_FFFF_8000_0000;
            end
            2'd1: begin
                lim_pos = 65'h0_FFFF_FFFF;
                lim_neg = '0;
                max_v   = 64'h0000_0000_FFFF_FFFF;
                min_v   = '0;
            end
            2'd2: begin
                lim_pos = {2'b00, {63{1'b1}}};
                lim_neg = {2'b01, 63'd0};
                max_v   = 64'h7FFF_FFFF_FFFF_FFFF;
                min_v   = 64'h8000_0000_0000_0000;
            end
            default: begin
                lim_pos = {1'b0, {64{1'b1}}};
                lim_neg = '0;
                max_v   = '1;
                min_v   = '0;
            end
        endcase
        // Unsigned ops have lim_neg = 0, so any negative nonzero magnitude overflows
        ovf = x.big | (x.sign ? (x.mag > lim_neg) : (x.mag > lim_pos));
        if (x.illegal) begin
            res64 = '0;
            flags = 5'b10000;
        end else if (x.is_nan | x.is_inf | ovf) begin
            res64 = (x.sign & ~x.is_nan) ? min_v : max_v;
            flags = 5'b10000;
        end else begin
            res64 = x.sign ? (64'd0 - x.mag[63:0]) : x.mag[63:0];
            flags = {x.rm_bad, 3'b000, x.nx};
        end
        if (!x.op[1]) begin
            res64 = {{32{res64[31]}}, res64[31:0]};
        end
        o.result = res64[XLEN-1:0];
        o.flags  = flags;
        return o;
    endfunction

    logic [STAGES-1:0] v_q;
    logic [STAGES-1:0] en;   // stage may capture this cycle
    logic [STAGES-1:0] ld;   // stage captures a valid entry this cycle
    logic [TAG_W-1:0]  tag_q [STAGES];
    dec_t              dec_c;
    rnd_t              rnd_c;
    res_t              res_c;
    res_t              res_q;
    logic              unused_class;

    // Classes that need no special handling (normals, subnormals)
    assign unused_class = ^{in_class[6:5], in_class[2:1]};

    // Backpressure chain: a stage is free when empty or its successor is free
    always_comb begin : ctrl
        logic go;
        en = '0;
        ld = '0;
        go = out_ready;
        for (int k = int'(STAGES) - 1; k >= 0; k--) begin
            go    = ~v_q[k] | go;
            en[k] = go;
        end
        ld[0] = en[0] & in_valid;
        for (int k = 1; k < int'(STAGES); k++) begin
            ld[k] = en[k] & v_q[k-1];
        end
    end

    // Stage valid bits; kill wins over any accept
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            v_q <= '0;
        end else if (kill) begin
            v_q <= '0;
        end else begin
            if (en[0]) v_q[0] <= in_valid;
            for (int k = 1; k < int'(STAGES); k++) begin
                if (en[k]) v_q[k] <= v_q[k-1];
            end
        end
    end

    // Tag travels alongside its operand
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < int'(STAGES); k++) tag_q[k] <= '0;
        end else begin
            if (ld[0]) tag_q[0] <= in_tag;
            for (int k = 1; k < int'(STAGES); k++) begin
                if (ld[k]) tag_q[k] <= tag_q[k-1];
            end
        end
    end

    assign dec_c = f_decode(in_data, in_class, in_op, in_rm);

    if (STAGES == 1) begin : g_one
        assign rnd_c = f_round(dec_c);
        assign res_c = f_saturate(rnd_c);
    end else if (STAGES == 2) begin : g_two
        dec_t s1_q;
        // S1 register; round and saturate share the final stage
        always_ff @(posedge clock or posedge reset) begin
            if (reset)      s1_q <= '0;
            else if (ld[0]) s1_q <= dec_c;
        end
        assign rnd_c = f_round(s1_q);
        assign res_c = f_saturate(rnd_c);
    end else begin : g_three
        dec_t s1_q;
        rnd_t s2_q;
        // S1 decode/shift register
        always_ff @(posedge clock or posedge reset) begin
            if (reset)      s1_q <= '0;
            else if (ld[0]) s1_q <= dec_c;
        end
        assign rnd_c = f_round(s1_q);
        // S2 rounding register
        always_ff @(posedge clock or posedge reset) begin
            if (reset)      s2_q <= '0;
            else if (ld[1]) s2_q <= rnd_c;
        end
        assign res_c = f_saturate(s2_q);
    end

    // Output register; holds while stalled because ld is low
    always_ff @(posedge clock or posedge reset) begin
        if (reset)               res_q <= '0;
        else if (ld[STAGES-1])   res_q <= res_c;
    end

    assign in_ready   = en[0];
    assign out_valid  = v_q[STAGES-1];
    assign out_tag    = tag_q[STAGES-1];
    assign out_result = res_q.result;
    assign out_flags  = res_q.flags;

`ifdef FP_CVT_F2I_FLAG_ACC_EN
    logic [4:0] flags_acc_q;

    // Sticky OR of delivered flags; a coincident clear keeps only the new flags
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            flags_acc_q <= '0;
        end else if (out_valid & out_ready) begin
            flags_acc_q <= flags_clr ? res_q.flags : (flags_acc_q | res_q.flags);
        end else if (flags_clr) begin
            flags_acc_q <= '0;
        end
    end

    assign flags_acc = flags_acc_q;
`endif

endmodule
